// File: rtl/ni_pkg.sv
// Request packet layout shared by the NI packetizer and its consumers.
// Define NI_TAIL_PARITY_EN to carry the XOR of the body data fields in the tail flit.
package ni_pkg;

    localparam int ADDR_WIDTH                 = 14;
    localparam int DATA_WIDTH                 = 32;
    localparam int FLIT_WIDTH                 = 16;
    localparam int TOTAL_FLITS                = 6;
    localparam int NUM_BODY_FLITS             = 4;
    localparam int REMAINING_BEATS_LENGTH_REQ = 2;

    typedef struct packed {
        logic [2:0] number_of_flits;
        logic [1:0] flag_bits;
        logic [2:0] mode_bits;
        logic [3:0] destination_addr;
        logic [3:0] source_addr;
    } head_flit_s;

    typedef struct packed {
        logic [14:0] data_bits;
        logic        flit_identifier;
    } body_flit_s;

    typedef struct packed {
        logic [14:0] data_bits;
        logic        flit_identifier;
    } tail_flit_s;

    typedef struct packed {
        head_flit_s                          head;
        body_flit_s [NUM_BODY_FLITS-1:0]     body;
        tail_flit_s                          tail;
    } req_packet_s;

    function automatic logic [DATA_WIDTH-1:0] get_data(input req_packet_s p);
        return {p.body[1].data_bits, p.body[2].data_bits, p.body[3].data_bits[14:13]};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] get_addr(input req_packet_s p);
        return p.body[0].data_bits[ADDR_WIDTH-1:0];
    endfunction

    // Exact inverse of get_data/get_addr; the low 13 bits of body[3] are padding.
    function automatic req_packet_s build_req_packet(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] data,
        input logic [2:0]            mode,
        input logic [1:0]            flags,
        input logic [3:0]            dest,
        input logic [3:0]            src
    );
        req_packet_s p;
        p = '0;
        p.head.number_of_flits  = 3'(TOTAL_FLITS);
        p.head.flag_bits        = flags;
        p.head.mode_bits        = mode;
        p.head.destination_addr = dest;
        p.head.source_addr      = src;
        p.body[0].data_bits     = {1'b0, addr};
        p.body[1].data_bits     = data[31:17];
        p.body[2].data_bits     = data[16:2];
        p.body[3].data_bits     = {data[1:0], 13'b0};
`ifdef NI_TAIL_PARITY_EN
        p.tail.data_bits        = p.body[0].data_bits ^ p.body[1].data_bits ^
                                  p.body[2].data_bits ^ p.body[3].data_bits;
`else
        p.tail.data_bits        = '0;
`endif
        p.tail.flit_identifier  = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/ni_req_packetizer.sv
// Serializes one write request into head / 4 body / tail flits over a valid-ready link.
// Tail content depends on NI_TAIL_PARITY_EN (see ni_pkg::build_req_packet).
module ni_req_packetizer
    import ni_pkg::*;
#(
    parameter logic [3:0] SRC_ADDR = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [2:0]            req_mode,
    input  logic [1:0]            req_flags,
    input  logic [3:0]            req_dest,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  flit_last
);

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_e;

    localparam logic [REMAINING_BEATS_LENGTH_REQ-1:0] LAST_BEAT =
        REMAINING_BEATS_LENGTH_REQ'(NUM_BODY_FLITS - 1);

    state_e                                state, state_nxt;
    logic [REMAINING_BEATS_LENGTH_REQ-1:0] beat, beat_nxt;
    req_packet_s                           pkt;
    logic                                  accept;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            pkt   <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            // Snapshot on acceptance so input changes cannot leak into a packet in flight.
            if (accept)
                pkt <= build_req_packet(req_addr, req_data, req_mode, req_flags,
                                        req_dest, SRC_ADDR);
        end
    end

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        req_ready  = 1'b0;
        flit_valid = 1'b0;
        flit_last  = 1'b0;
        flit_out   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = HEAD;
            end
            HEAD: begin
                flit_valid = 1'b1;
                flit_out   = pkt.head;
                if (flit_ready) begin
                    state_nxt = BODY;
                    beat_nxt  = '0;
                end
            end
            BODY: begin
                flit_valid = 1'b1;
                flit_out   = pkt.body[beat];
                if (flit_ready) begin
                    if (beat != LAST_BEAT)
                        beat_nxt = beat + 1'b1;
                    else
                        state_nxt = TAIL;
                end
            end
            TAIL: begin
                flit_valid = 1'b1;
                flit_last  = 1'b1;
                flit_out   = pkt.tail;
                if (flit_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ni_req_packetizer.sv
// Self-checking bench for ni_req_packetizer: directed scenarios plus randomized round-trip.
`timescale 1ns/1ps
module tb_ni_req_packetizer;
    import ni_pkg::*;

    localparam logic [3:0] SRC = 4'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready;
    logic [13:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_mode;
    logic [1:0]  req_flags;
    logic [3:0]  req_dest;
    logic [15:0] flit_out;
    logic        flit_valid, flit_ready, flit_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ni_req_packetizer #(.SRC_ADDR(SRC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_mode(req_mode),
        .req_flags(req_flags), .req_dest(req_dest),
        .flit_out(flit_out), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .flit_last(flit_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference flits computed straight from the field rules.
    function automatic logic [5:0][15:0] model(input logic [13:0] a, input logic [31:0] d,
                                               input logic [2:0] m, input logic [1:0] f,
                                               input logic [3:0] ds);
        logic [5:0][15:0] r;
        logic [14:0]      b[4];
        logic [14:0]      t;
        b[0] = 15'(a);
        b[1] = 15'(d >> 17);
        b[2] = 15'((d >> 2) & 32'h7fff);
        b[3] = 15'((d & 32'h3) << 13);
`ifdef NI_TAIL_PARITY_EN
        t = b[0] ^ b[1] ^ b[2] ^ b[3];
`else
        t = 15'h0;
`endif
        r[0] = 16'(6 * 8192 + int'(f) * 2048 + int'(m) * 256 + int'(ds) * 16 + int'(SRC));
        for (int k = 0; k < 4; k++) r[k+1] = {b[k], 1'b0};
        r[5] = {t, 1'b1};
        return r;
    endfunction

    task automatic drive_req(input logic [13:0] a, input logic [31:0] d, input logic [2:0] m,
                             input logic [1:0] f, input logic [3:0] ds);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_mode  = m;
        req_flags = f;
        req_dest  = ds;
    endtask

    // Entered on the falling edge of the first cycle after acceptance; leaves on the
    // falling edge right after the tail handshake.
    task automatic collect(input logic [5:0][15:0] exp, input int stall_pct, input int stall_idx,
                           output logic [5:0][15:0] got);
        int          idx = 0;
        int          cyc = 0;
        int          hold = 0;
        logic        stall;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_out = '0;
        logic        prev_last = 1'b0;
        got = '0;
        while (idx < 6 && cyc < 200) begin
            chk("flit_valid", 32'(flit_valid), 32'd1);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (prev_stall) begin
                chk("hold_out", 32'(flit_out), 32'(prev_out));
                chk("hold_last", 32'(flit_last), 32'(prev_last));
            end
            stall = ($urandom_range(99) < stall_pct) || (idx == stall_idx && hold < 3);
            if (idx == stall_idx && hold < 3) hold++;
            flit_ready = !stall;
            if (!stall) begin
                chk("flit_out", 32'(flit_out), 32'(exp[idx]));
                chk("flit_last", 32'(flit_last), 32'(idx == 5));
                got[idx] = flit_out;
                idx++;
            end
            prev_stall = stall;
            prev_out   = flit_out;
            prev_last  = flit_last;
            @(negedge clk);
            cyc++;
        end
        if (idx < 6) chk("timeout", 32'(idx), 32'd6);
        flit_ready = 1'b0;
        chk("idle_valid", 32'(flit_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [5:0][15:0] eb, got, ea;
        req_packet_s      pkt;
        logic [13:0]      a;
        logic [31:0]      d;
        logic [2:0]       m;
        logic [1:0]       f;
        logic [3:0]       ds;

        req_valid = 0; req_addr = 0; req_data = 0; req_mode = 0;
        req_flags = 0; req_dest = 0; flit_ready = 0;

        repeat (3) @(negedge clk);
        chk("rst_flit_valid", 32'(flit_valid), 32'd0);
        chk("rst_flit_last", 32'(flit_last), 32'd0);
        chk("rst_flit_out", 32'(flit_out), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        chk("rel_flit_valid", 32'(flit_valid), 32'd0);

        // Basic packet with known flit values
        eb[0] = 16'hC150; eb[1] = 16'h3578; eb[2] = 16'hDEAC;
        eb[3] = 16'hDF76; eb[4] = 16'hC000;
`ifdef NI_TAIL_PARITY_EN
        eb[5] = 16'hF4A3;
`else
        eb[5] = 16'h0001;
`endif
        drive_req(14'h1ABC, 32'hDEADBEEF, 3'b001, 2'b00, 4'h5);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        collect(eb, 0, -1, got);

        // Backpressure: three stalled cycles on body[2]
        drive_req(14'h1ABC, 32'hDEADBEEF, 3'b001, 2'b00, 4'h5);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        collect(eb, 0, 3, got);

        // Inputs scrambled after acceptance must not reach the packet
        drive_req(14'h1ABC, 32'hDEADBEEF, 3'b001, 2'b00, 4'h5);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        req_data = 32'h0; req_addr = 14'h3FFF; req_mode = 3'b111; req_flags = 2'b11; req_dest = 4'hA;
        collect(eb, 20, -1, got);

        // Reset in the middle of the body
        drive_req(14'h0123, 32'h89ABCDEF, 3'b010, 2'b01, 4'h3);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        flit_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", 32'(flit_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(flit_valid), 32'd0);
        chk("mid_rst_last", 32'(flit_last), 32'd0);
        chk("mid_rst_out", 32'(flit_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(flit_valid), 32'd0);
            chk("post_rst_ready", 32'(req_ready), 32'd1);
        end
        flit_ready = 1'b0;

        // Back-to-back with req_valid held high
        ea = model(14'h2A55, 32'h12345678, 3'b100, 2'b10, 4'hC);
        eb = model(14'h155A, 32'hCAFEF00D, 3'b011, 2'b01, 4'h7);
        drive_req(14'h2A55, 32'h12345678, 3'b100, 2'b10, 4'hC);
        @(posedge clk); @(negedge clk);
        drive_req(14'h155A, 32'hCAFEF00D, 3'b011, 2'b01, 4'h7);
        collect(ea, 0, -1, got);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        collect(eb, 0, -1, got);

        // Randomized packets with random backpressure and round-trip recovery
        for (int n = 0; n < 1000; n++) begin
            a  = 14'($urandom);
            d  = $urandom;
            m  = 3'($urandom);
            f  = 2'($urandom);
            ds = 4'($urandom);
            if ($urandom_range(3) == 0) @(negedge clk);
            drive_req(a, d, m, f, ds);
            @(posedge clk); @(negedge clk);
            req_valid = 1'b0;
            collect(model(a, d, m, f, ds), 30, -1, got);
            pkt.head = head_flit_s'(got[0]);
            for (int k = 0; k < 4; k++) pkt.body[k] = body_flit_s'(got[k+1]);
            pkt.tail = tail_flit_s'(got[5]);
            chk("rt_data", get_data(pkt), d);
            chk("rt_addr", 32'(got[1][14:1]), 32'(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
